// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared FSM states, codec device address and headphone volume limits
package codec_cfg_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SEND, NEXT, DONE, ERROR} state_t;
    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
    localparam logic [6:0] VOL_INIT_DEF = 7'd57;
    localparam logic [6:0] VOL_MIN_DEF = 7'd47;
    localparam logic [6:0] VOL_MAX_DEF = 7'd127;
    localparam logic [6:0] VOL_STEP_DEF = 7'd5;
endpackage

// File: rtl/codec_vol_ctrl.sv
// codec_vol_ctrl: saturating headphone volume register; keys act only when CODEC_VOL_KEY_EN is defined
module codec_vol_ctrl
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] VOL_INIT = VOL_INIT_DEF,
    parameter logic [6:0] VOL_MIN = VOL_MIN_DEF,
    parameter logic [6:0] VOL_MAX = VOL_MAX_DEF,
    parameter logic [6:0] VOL_STEP = VOL_STEP_DEF
) (
    input logic clk_in,
    input logic rst,
    input logic key_up,
    input logic key_dn,
    output logic [6:0] volume,
    output logic changed
);
    logic up, dn;
    logic [7:0] vol_up;
    logic [6:0] vol_nxt;
`ifdef CODEC_VOL_KEY_EN
    assign up = key_up & ~key_dn;
    assign dn = key_dn & ~key_up;
`else
    logic unused_keys;
    assign unused_keys = key_up ^ key_dn;
    assign up = 1'b0;
    assign dn = 1'b0;
`endif
    // saturating step: up is summed in 8 bits so overflow past 127 clamps cleanly
    always_comb begin
        vol_up = {1'b0, volume} + {1'b0, VOL_STEP};
        vol_nxt = up ? ((vol_up > {1'b0, VOL_MAX}) ? VOL_MAX : vol_up[6:0])
                : dn ? (({1'b0, volume} < {1'b0, VOL_MIN} + {1'b0, VOL_STEP}) ? VOL_MIN : volume - VOL_STEP)
                : volume;
    end
    assign changed = vol_nxt != volume;
    // volume register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) volume <= VOL_INIT;
        else volume <= vol_nxt;
    end
endmodule

// File: rtl/codec_config_seq.sv
// codec_config_seq: writes a register table to the codec over I2C with retry; volume keys via CODEC_VOL_KEY_EN
module codec_config_seq
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS = 10,
    parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR,
    parameter int WAIT_CYCLES = 10,
    parameter int MAX_RETRY = 3,
    parameter int VOL_L_IDX = 2,
    parameter int VOL_R_IDX = 3,
    parameter logic [6:0] VOL_INIT = VOL_INIT_DEF,
    parameter logic [6:0] VOL_MIN = VOL_MIN_DEF,
    parameter logic [6:0] VOL_MAX = VOL_MAX_DEF,
    parameter logic [6:0] VOL_STEP = VOL_STEP_DEF
) (
    input logic clk_in,
    input logic rst,
    input logic restart,
    input logic key_up,
    input logic key_dn,
    output logic [3:0] reg_idx,
    input logic [15:0] reg_word,
    output logic [23:0] iic_data,
    output logic iic_start,
    input logic iic_idle,
    input logic iic_ack_n,
    output logic busy,
    output logic done,
    output logic error,
    output logic [6:0] volume
);
    state_t state;
    logic [3:0] idx, retry;
    logic [15:0] cnt, word;
    logic pending, vol_chg, trig;

    codec_vol_ctrl #(
        .VOL_INIT(VOL_INIT), .VOL_MIN(VOL_MIN), .VOL_MAX(VOL_MAX), .VOL_STEP(VOL_STEP)
    ) u_vol (
        .clk_in(clk_in), .rst(rst), .key_up(key_up), .key_dn(key_dn),
        .volume(volume), .changed(vol_chg)
    );

    assign trig = restart | vol_chg;
    assign reg_idx = idx;
`ifdef CODEC_VOL_KEY_EN
    assign word = (idx == 4'(VOL_L_IDX) || idx == 4'(VOL_R_IDX))
                ? {reg_word[15:9], 1'b0, reg_word[7], volume} : reg_word;
`else
    assign word = reg_word;
`endif
    assign busy = state inside {LOAD, WAIT, SEND, NEXT};
    assign done = state == DONE;
    assign error = state == ERROR;

    // sequencer: fetch, hold request, await master, retry on NACK, rerun when a rewrite is pending
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iic_start <= 1'b0;
            iic_data <= '0;
            idx <= '0;
            retry <= '0;
            cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (trig && busy) pending <= 1'b1;
            case (state)
                IDLE: begin
                    idx <= '0;
                    retry <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    iic_data <= {DEV_ADDR, 1'b0, word};
                    iic_start <= 1'b1;
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(WAIT_CYCLES - 1)) state <= SEND;
                end
                SEND: if (iic_idle) begin
                    iic_start <= 1'b0;
                    if (!iic_ack_n) state <= NEXT;
                    else if (retry == 4'(MAX_RETRY)) state <= ERROR;
                    else begin
                        retry <= retry + 4'd1;
                        state <= LOAD;
                    end
                end
                NEXT: begin
                    retry <= '0;
                    if (idx == 4'(NUM_REGS - 1)) begin
                        idx <= '0;
                        pending <= 1'b0;
                        state <= (pending || trig) ? LOAD : DONE;
                    end else begin
                        idx <= idx + 4'd1;
                        state <= LOAD;
                    end
                end
                default: if (trig) begin
                    idx <= '0;
                    retry <= '0;
                    pending <= 1'b0;
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq: randomized table/latency/NACK bench with a transfer-list reference model
module tb_codec_config_seq;
    localparam int NUM_REGS = 10;
    localparam int MAX_RETRY = 3;
`ifdef CODEC_VOL_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic clk = 0, rst = 1, restart = 0, key_up = 0, key_dn = 0, iic_idle = 1, iic_ack_n = 0;
    logic [3:0] reg_idx;
    logic [15:0] reg_word;
    logic [23:0] iic_data;
    logic iic_start, busy, done, error;
    logic [6:0] volume;

    logic [15:0] tbl [16];
    int plan [16];
    int nack_left [16];
    logic [27:0] log_q [$];
    logic [27:0] exp_q [$];
    int passed = 0, total = 0, nchg = 0;
    logic [6:0] vol_m = 7'd57;
    bit prev = 0, cur_nack = 0;
    int lat = 0;

    codec_config_seq dut (
        .clk_in(clk), .rst(rst), .restart(restart), .key_up(key_up), .key_dn(key_dn),
        .reg_idx(reg_idx), .reg_word(reg_word), .iic_data(iic_data), .iic_start(iic_start),
        .iic_idle(iic_idle), .iic_ack_n(iic_ack_n), .busy(busy), .done(done), .error(error),
        .volume(volume)
    );

    always #5 clk = ~clk;
    assign reg_word = tbl[reg_idx];

    // I2C master stand-in: logs each request, goes busy for a random time, answers ACK/NACK by plan
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                iic_idle = 1;
                lat = 0;
                prev = 0;
            end else begin
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        iic_idle = 1;
                        iic_ack_n = cur_nack;
                    end
                end
                if (iic_start && !prev) begin
                    log_q.push_back({reg_idx, iic_data});
                    cur_nack = nack_left[reg_idx] > 0;
                    if (cur_nack) nack_left[reg_idx]--;
                    iic_idle = 0;
                    lat = $urandom_range(1, 20);
                end
                prev = iic_start;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] vol_next(input logic [6:0] v, input bit up, input bit dn);
        int r;
        r = int'(v) + (up ? 5 : 0) - (dn ? 5 : 0);
        if (!KEY_EN || (up && dn)) r = int'(v);
        return 7'(r > 127 ? 127 : (r < 47 ? 47 : r));
    endfunction

    function automatic logic [27:0] exp_entry(input int i, input logic [6:0] v);
        logic [15:0] w;
        w = tbl[i];
        if (KEY_EN && (i == 2 || i == 3)) w = {tbl[i][15:9], 1'b0, tbl[i][7], v};
        return {4'(i), 7'h1A, 1'b0, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic setup(input int max_nack);
        for (int i = 0; i < 16; i++) begin
            tbl[i] = 16'($urandom);
            plan[i] = $urandom_range(0, max_nack);
            nack_left[i] = plan[i];
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic set_nack(input int i, input int n);
        plan[i] = n;
        nack_left[i] = n;
    endtask

    task automatic add_run(input logic [6:0] v);
        for (int i = 0; i < NUM_REGS; i++) begin
            int tries;
            tries = plan[i] > MAX_RETRY ? MAX_RETRY + 1 : plan[i] + 1;
            repeat (tries) exp_q.push_back(exp_entry(i, v));
            if (plan[i] > MAX_RETRY) break;
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check({tag, "_xfer"}, log_q[i], exp_q[i]);
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_end"}, 32'(n < 20000), 1);
    endtask

    task automatic wait_idx(input string tag, input logic [3:0] i);
        int n;
        n = 0;
        while (!(reg_idx == i && iic_start) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach"}, 32'(n < 5000), 1);
    endtask

    task automatic pulse(input bit r, input bit u, input bit d);
        if (u || d) begin
            logic [6:0] nv;
            nv = vol_next(vol_m, u, d);
            nchg += (nv != vol_m) ? 1 : 0;
            vol_m = nv;
        end
        restart = r;
        key_up = u;
        key_dn = d;
        @(negedge clk);
        restart = 0;
        key_up = 0;
        key_dn = 0;
    endtask

    initial begin
        setup(0);
        repeat (3) @(negedge clk);
        check("rst_start", iic_start, 0);
        check("rst_data", iic_data, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_vol", volume, 57);
        check("rst_idx", reg_idx, 0);
        // plain run after reset release, always ACK
        add_run(vol_m);
        rst = 0;
        wait_end("s1");
        check_log("s1");
        check("s1_dev", log_q[0][23:16], 8'h34);
        check("s1_status", {busy, done, error}, 3'b010);
        // idx 4 NACKed twice
        setup(0);
        set_nack(4, 2);
        add_run(vol_m);
        pulse(1, 0, 0);
        wait_end("s2");
        check_log("s2");
        check("s2_status", {busy, done, error}, 3'b010);
        // random NACK pattern within the retry budget
        setup(2);
        add_run(vol_m);
        pulse(1, 0, 0);
        wait_end("sr");
        check_log("sr");
        check("sr_status", {busy, done, error}, 3'b010);
        // idx 1 NACKs forever
        setup(0);
        set_nack(1, 100);
        add_run(vol_m);
        pulse(1, 0, 0);
        wait_end("s3");
        repeat (40) @(negedge clk);
        check_log("s3");
        check("s3_status", {busy, done, error}, 3'b001);
        check("s3_start", iic_start, 0);
        // restart out of ERROR
        setup(0);
        add_run(vol_m);
        pulse(1, 0, 0);
        wait_end("s4");
        check_log("s4");
        check("s4_status", {busy, done, error}, 3'b010);
        // volume up to the ceiling from DONE, later presses land while busy
        setup(0);
        nchg = 0;
        for (int k = 0; k < 14; k++) begin
            pulse(0, 1, 0);
            repeat (2) @(negedge clk);
            check("ka_vol", volume, vol_m);
        end
        wait_end("ka");
        check("ka_count", log_q.size(), nchg == 0 ? 0 : 20);
        add_run(vol_m);
        for (int i = 0; i < 10 && log_q.size() >= 10; i++)
            check("ka_xfer", log_q[log_q.size() - 10 + i], exp_q[i]);
        pulse(0, 1, 0);
        repeat (3) @(negedge clk);
        check("ka_sat_vol", volume, vol_m);
        check("ka_sat_done", done, 1);
        pulse(0, 1, 1);
        repeat (3) @(negedge clk);
        check("ka_both_vol", volume, vol_m);
        check("ka_both_done", done, 1);
        check("ka_sat_count", log_q.size(), nchg == 0 ? 0 : 20);
        // volume down to the floor while idx 6 is in flight
        setup(0);
        add_run(vol_m);
        nchg = 0;
        pulse(1, 0, 0);
        wait_idx("kb", 4'd6);
        for (int k = 0; k < 16; k++) begin
            pulse(0, 0, 1);
            @(negedge clk);
        end
        check("kb_vol", volume, vol_m);
        if (nchg > 0) add_run(vol_m);
        wait_end("kb");
        check_log("kb");
        check("kb_status", {busy, done, error}, 3'b010);
        // reset in the middle of idx 5
        setup(0);
        pulse(1, 0, 0);
        wait_idx("rm", 4'd5);
        rst = 1;
        #1;
        check("rm_start", iic_start, 0);
        check("rm_data", iic_data, 0);
        check("rm_status", {busy, done, error}, 0);
        check("rm_vol", volume, 57);
        @(negedge clk);
        log_q.delete();
        exp_q.delete();
        vol_m = 7'd57;
        add_run(vol_m);
        rst = 0;
        wait_end("rm");
        check_log("rm");
        check("rm_done", {busy, done, error}, 3'b010);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
